// File: rtl/axo32_lsu_if.sv
// Bundles the three handshakes of the load/store unit: instruction offer from
// execute, the single-beat memory bus and the writeback result channel.
interface axo32_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        fault;
    logic [3:0]  fault_cause;

    modport master (
        input  in_valid, in_insn, in_addr, in_wdata, mem_ack, mem_err, mem_rdata, wb_ready,
        output in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_we, wb_data, fault, fault_cause
    );

    modport slave (
        output in_valid, in_insn, in_addr, in_wdata, mem_ack, mem_err, mem_rdata, wb_ready,
        input  in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_we, wb_data, fault, fault_cause
    );
endinterface

// File: rtl/axo32_lsu.sv
// RV32 load/store unit: decodes one memory instruction, performs a single bus
// beat with timeout, and returns the aligned load value or an exception.
module axo32_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    axo32_lsu_if.master bus
);
    localparam int unsigned CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    f3_q;
    logic          is_store_q;
    logic [31:0]   addr_q;
    logic          mem_we_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;
    logic [4:0]    wb_rd_q;
    logic          wb_we_q;
    logic [31:0]   wb_data_q;
    logic          fault_q;
    logic [3:0]    cause_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_load_d, is_store_d, legal_d, misal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic        timeout_hit;
    logic        unused_insn;

    assign opcode      = bus.in_insn[6:0];
    assign f3          = bus.in_insn[14:12];
    assign unused_insn = ^bus.in_insn[31:15];

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_load_d  = (opcode == OP_LOAD);
        is_store_d = (opcode == OP_STORE);
        legal_d    = 1'b0;
        if (is_load_d)
            legal_d = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
        else if (is_store_d)
            legal_d = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        misal_d = ((f3[1:0] == 2'b01) && bus.in_addr[0]) ||
                  ((f3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
        be_d    = 4'b1111;
        wdata_d = bus.in_wdata;
        case (f3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << bus.in_addr[1:0];
                wdata_d = {4{bus.in_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << bus.in_addr[1:0];
                wdata_d = {2{bus.in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        lane     = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        load_val = lane;
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = (legal_d && !misal_d) ? S_BUS : S_RESP;
            S_BUS: begin
                if (bus.mem_ack) begin
                    state_d = S_RESP;
                end else if (cnt_q == CW'(BUS_TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    timeout_hit = 1'b1;
                end
            end
            S_RESP: if (bus.wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
            cause_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    cnt_q       <= '0;
                    f3_q        <= f3;
                    is_store_q  <= is_store_d;
                    addr_q      <= bus.in_addr;
                    mem_we_q    <= is_store_d;
                    mem_be_q    <= be_d;
                    mem_wdata_q <= wdata_d;
                    wb_rd_q     <= bus.in_insn[11:7];
                    wb_we_q     <= 1'b0;
                    if (!legal_d) begin
                        fault_q   <= 1'b1;
                        cause_q   <= 4'd2;
                        wb_data_q <= bus.in_addr;
                    end else if (misal_d) begin
                        fault_q   <= 1'b1;
                        cause_q   <= is_store_d ? 4'd6 : 4'd4;
                        wb_data_q <= bus.in_addr;
                    end else begin
                        fault_q   <= 1'b0;
                        cause_q   <= 4'd0;
                        wb_data_q <= '0;
                    end
                end
                S_BUS: begin
                    if (bus.mem_ack && !bus.mem_err) begin
                        fault_q   <= 1'b0;
                        cause_q   <= 4'd0;
                        wb_data_q <= is_store_q ? 32'h0 : load_val;
                        wb_we_q   <= !is_store_q && (wb_rd_q != 5'd0);
                    end else if (bus.mem_ack || timeout_hit) begin
                        fault_q   <= 1'b1;
                        cause_q   <= is_store_q ? 4'd7 : 4'd5;
                        wb_data_q <= addr_q;
                        wb_we_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // mem_req decodes straight from the state flop, so an async reset drops it at once.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.mem_req     = (state_q == S_BUS);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.mem_addr    = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.wb_valid    = (state_q == S_RESP);
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_we       = wb_we_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;
endmodule

// File: tb/tb_axo32_lsu.sv
// Directed bench for axo32_lsu: each task drives one scenario and compares
// outputs against hand-computed values.
module tb_axo32_lsu;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    axo32_lsu_if bus ();

    axo32_lsu #(.BUS_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] insn, input logic [31:0] addr, input logic [31:0] wdata);
        bus.in_valid = 1'b1;
        bus.in_insn  = insn;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata, input logic err);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        bus.mem_err   = err;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); else pass_cnt++;
        chk_cnt++; if (bus.mem_be !== 4'h0) $display("FAIL rst_mem_be got=%0h exp=0", bus.mem_be); else pass_cnt++;
        chk_cnt++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); else pass_cnt++;
        chk_cnt++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); else pass_cnt++;
        chk_cnt++; if ({bus.wb_valid, bus.wb_we, bus.fault, bus.fault_cause} !== 7'h0) $display("FAIL rst_wb got=%0h exp=0", {bus.wb_valid, bus.wb_we, bus.fault, bus.fault_cause}); else pass_cnt++;
        chk_cnt++; if ({bus.wb_rd, bus.wb_data} !== 37'h0) $display("FAIL rst_wb_data got=%0h exp=0", {bus.wb_rd, bus.wb_data}); else pass_cnt++;
    endtask

    task automatic test_lb_sign();
        offer(32'h0000_0283, 32'h0000_1003, 32'h0);
        chk_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL lb_req got=%0h exp=1", bus.mem_req); else pass_cnt++;
        chk_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL lb_we got=%0h exp=0", bus.mem_we); else pass_cnt++;
        chk_cnt++; if (bus.mem_be !== 4'b1000) $display("FAIL lb_be got=%0b exp=1000", bus.mem_be); else pass_cnt++;
        chk_cnt++; if (bus.mem_addr !== 32'h0000_1000) $display("FAIL lb_addr got=%0h exp=1000", bus.mem_addr); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL lb_busy_ready got=%0h exp=0", bus.in_ready); else pass_cnt++;
        ack(32'h80FF_FFFF, 1'b0);
        chk_cnt++; if (bus.wb_valid !== 1'b1) $display("FAIL lb_wb_valid got=%0h exp=1", bus.wb_valid); else pass_cnt++;
        chk_cnt++; if (bus.wb_data !== 32'hFFFF_FF80) $display("FAIL lb_wb_data got=%0h exp=ffffff80", bus.wb_data); else pass_cnt++;
        chk_cnt++; if ({bus.wb_we, bus.fault, bus.wb_rd} !== {1'b1, 1'b0, 5'd5}) $display("FAIL lb_wb_ctl got=%0h exp=%0h", {bus.wb_we, bus.fault, bus.wb_rd}, {1'b1, 1'b0, 5'd5}); else pass_cnt++;
        chk_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL lb_req_drop got=%0h exp=0", bus.mem_req); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.wb_valid, bus.in_ready} !== 2'b01) $display("FAIL lb_idle got=%0b exp=01", {bus.wb_valid, bus.in_ready}); else pass_cnt++;
    endtask

    task automatic test_sh_store();
        offer(32'h0000_1023, 32'h0000_2002, 32'h1234_ABCD);
        chk_cnt++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_1100) $display("FAIL sh_ctl got=%0b exp=111100", {bus.mem_req, bus.mem_we, bus.mem_be}); else pass_cnt++;
        chk_cnt++; if (bus.mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got=%0h exp=abcdabcd", bus.mem_wdata); else pass_cnt++;
        tick();
        chk_cnt++; if ({bus.mem_req, bus.mem_be, bus.mem_addr} !== {1'b1, 4'b1100, 32'h2000}) $display("FAIL sh_hold got=%0h exp=%0h", {bus.mem_req, bus.mem_be, bus.mem_addr}, {1'b1, 4'b1100, 32'h2000}); else pass_cnt++;
        chk_cnt++; if (bus.mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata_hold got=%0h exp=abcdabcd", bus.mem_wdata); else pass_cnt++;
        ack(32'hFFFF_FFFF, 1'b0);
        chk_cnt++; if ({bus.wb_valid, bus.wb_we, bus.fault} !== 3'b100) $display("FAIL sh_wb got=%0b exp=100", {bus.wb_valid, bus.wb_we, bus.fault}); else pass_cnt++;
        chk_cnt++; if (bus.wb_data !== 32'h0) $display("FAIL sh_wb_data got=%0h exp=0", bus.wb_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_sb_replicate();
        offer(32'h0000_0023, 32'h0000_0005, 32'h0000_00C3);
        chk_cnt++; if ({bus.mem_be, bus.mem_addr} !== {4'b0010, 32'h4}) $display("FAIL sb_be_addr got=%0h exp=%0h", {bus.mem_be, bus.mem_addr}, {4'b0010, 32'h4}); else pass_cnt++;
        chk_cnt++; if (bus.mem_wdata !== 32'hC3C3_C3C3) $display("FAIL sb_wdata got=%0h exp=c3c3c3c3", bus.mem_wdata); else pass_cnt++;
        ack(32'h0, 1'b0);
        tick();
    endtask

    task automatic test_misaligned();
        offer(32'h0000_2383, 32'h0000_3001, 32'h0);
        chk_cnt++; if ({bus.mem_req, bus.wb_valid, bus.fault} !== 3'b011) $display("FAIL lw_mis_ctl got=%0b exp=011", {bus.mem_req, bus.wb_valid, bus.fault}); else pass_cnt++;
        chk_cnt++; if (bus.fault_cause !== 4'd4) $display("FAIL lw_mis_cause got=%0d exp=4", bus.fault_cause); else pass_cnt++;
        chk_cnt++; if ({bus.wb_we, bus.wb_data} !== {1'b0, 32'h3001}) $display("FAIL lw_mis_data got=%0h exp=3001", {bus.wb_we, bus.wb_data}); else pass_cnt++;
        tick();
        offer(32'h0000_1023, 32'h0000_0101, 32'h0);
        chk_cnt++; if ({bus.mem_req, bus.fault, bus.fault_cause} !== {2'b01, 4'd6}) $display("FAIL sh_mis got=%0h exp=%0h", {bus.mem_req, bus.fault, bus.fault_cause}, {2'b01, 4'd6}); else pass_cnt++;
        tick();
    endtask

    task automatic test_illegal();
        offer(32'h0000_0033, 32'h0000_0055, 32'h0);
        chk_cnt++; if ({bus.mem_req, bus.wb_valid, bus.fault, bus.fault_cause} !== {3'b011, 4'd2}) $display("FAIL ill_op got=%0h exp=%0h", {bus.mem_req, bus.wb_valid, bus.fault, bus.fault_cause}, {3'b011, 4'd2}); else pass_cnt++;
        chk_cnt++; if (bus.wb_data !== 32'h55) $display("FAIL ill_op_data got=%0h exp=55", bus.wb_data); else pass_cnt++;
        tick();
        offer(32'h0000_3003, 32'h0000_0000, 32'h0);
        chk_cnt++; if ({bus.mem_req, bus.fault, bus.fault_cause} !== {2'b01, 4'd2}) $display("FAIL ill_f3 got=%0h exp=%0h", {bus.mem_req, bus.fault, bus.fault_cause}, {2'b01, 4'd2}); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        offer(32'h0000_5183, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL to_req_c%0d got=%0h exp=1", i, bus.mem_req); else pass_cnt++;
            if (i < 3) tick();
        end
        tick();
        chk_cnt++; if ({bus.mem_req, bus.wb_valid, bus.fault, bus.fault_cause} !== {3'b011, 4'd5}) $display("FAIL to_fault got=%0h exp=%0h", {bus.mem_req, bus.wb_valid, bus.fault, bus.fault_cause}, {3'b011, 4'd5}); else pass_cnt++;
        chk_cnt++; if ({bus.wb_we, bus.wb_data} !== {1'b0, 32'h10}) $display("FAIL to_data got=%0h exp=10", {bus.wb_we, bus.wb_data}); else pass_cnt++;
        tick();
    endtask

    task automatic test_ack_beats_timeout();
        offer(32'h0000_4203, 32'h0000_0021, 32'h0);
        chk_cnt++; if ({bus.mem_be, bus.mem_addr} !== {4'b0010, 32'h20}) $display("FAIL lbu_be_addr got=%0h exp=%0h", {bus.mem_be, bus.mem_addr}, {4'b0010, 32'h20}); else pass_cnt++;
        tick(); tick(); tick();
        ack(32'h0000_A500, 1'b0);
        chk_cnt++; if ({bus.wb_valid, bus.fault, bus.wb_we} !== 3'b101) $display("FAIL lbu_prio got=%0b exp=101", {bus.wb_valid, bus.fault, bus.wb_we}); else pass_cnt++;
        chk_cnt++; if (bus.wb_data !== 32'h0000_00A5) $display("FAIL lbu_data got=%0h exp=a5", bus.wb_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_store_err_stall();
        bus.wb_ready = 1'b0;
        offer(32'h0000_2023, 32'h0000_0040, 32'hDEAD_BEEF);
        chk_cnt++; if ({bus.mem_we, bus.mem_be, bus.mem_wdata} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) $display("FAIL sw_bus got=%0h exp=%0h", {bus.mem_we, bus.mem_be, bus.mem_wdata}, {1'b1, 4'hF, 32'hDEAD_BEEF}); else pass_cnt++;
        ack(32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_cnt++; if ({bus.wb_valid, bus.fault, bus.fault_cause, bus.wb_we, bus.wb_data} !== {2'b11, 4'd7, 1'b0, 32'h40}) $display("FAIL sw_err_c%0d got=%0h exp=%0h", i, {bus.wb_valid, bus.fault, bus.fault_cause, bus.wb_we, bus.wb_data}, {2'b11, 4'd7, 1'b0, 32'h40}); else pass_cnt++;
            chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL sw_stall_ready_c%0d got=%0h exp=0", i, bus.in_ready); else pass_cnt++;
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        chk_cnt++; if ({bus.wb_valid, bus.in_ready} !== 2'b01) $display("FAIL sw_idle got=%0b exp=01", {bus.wb_valid, bus.in_ready}); else pass_cnt++;
    endtask

    task automatic test_rd_zero_and_stray_ack();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack   = 1'b0;
        chk_cnt++; if ({bus.wb_valid, bus.in_ready, bus.mem_req} !== 3'b010) $display("FAIL stray_ack got=%0b exp=010", {bus.wb_valid, bus.in_ready, bus.mem_req}); else pass_cnt++;
        offer(32'h0000_2003, 32'h0000_0200, 32'h0);
        ack(32'h0000_0005, 1'b0);
        chk_cnt++; if ({bus.wb_valid, bus.wb_we, bus.fault, bus.wb_data} !== {3'b100, 32'h5}) $display("FAIL rd0 got=%0h exp=%0h", {bus.wb_valid, bus.wb_we, bus.fault, bus.wb_data}, {3'b100, 32'h5}); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        offer(32'h0000_2483, 32'h0000_0100, 32'h0);
        chk_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL rmid_req got=%0h exp=1", bus.mem_req); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({bus.mem_req, bus.wb_valid, bus.in_ready} !== 3'b001) $display("FAIL rmid_drop got=%0b exp=001", {bus.mem_req, bus.wb_valid, bus.in_ready}); else pass_cnt++;
        chk_cnt++; if ({bus.mem_be, bus.mem_addr} !== 36'h0) $display("FAIL rmid_bus got=%0h exp=0", {bus.mem_be, bus.mem_addr}); else pass_cnt++;
        #1 rst_n = 1'b1;
        tick();
        chk_cnt++; if ({bus.wb_valid, bus.mem_req} !== 2'b00) $display("FAIL rmid_no_wb got=%0b exp=00", {bus.wb_valid, bus.mem_req}); else pass_cnt++;
        offer(32'h0000_2483, 32'h0000_0104, 32'h0);
        chk_cnt++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h104}) $display("FAIL rlw_req got=%0h exp=%0h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h104}); else pass_cnt++;
        ack(32'h1122_3344, 1'b0);
        chk_cnt++; if ({bus.wb_valid, bus.wb_we, bus.fault, bus.wb_rd, bus.wb_data} !== {3'b110, 5'd9, 32'h1122_3344}) $display("FAIL rlw_wb got=%0h exp=%0h", {bus.wb_valid, bus.wb_we, bus.fault, bus.wb_rd, bus.wb_data}, {3'b110, 5'd9, 32'h1122_3344}); else pass_cnt++;
        tick();
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_insn   = 32'h0;
        bus.in_addr   = 32'h0;
        bus.in_wdata  = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.wb_ready  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        test_reset();
        #15 rst_n = 1'b1;
        tick();
        test_lb_sign();
        test_sh_store();
        test_sb_replicate();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_ack_beats_timeout();
        test_store_err_stall();
        test_rd_zero_and_stray_ack();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
